// File: rtl/merge_seq_pkg.sv
// Shared types and helpers for the merge pass sequencer.
// seq_state_t: sequencer FSM states.
// run_len(): run length of a pass; last_pair(): true when a base address is the last pair of a pass.
package merge_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_NEXT_PAIR,
    ST_NEXT_PASS,
    ST_DONE
  } seq_state_t;

  // WAIT-state watchdog counter width (largest limit is 4*128+16 = 528).
  localparam int WD_CNT_W = 10;

  // Run length for a pass: 1 << pass. Nine bits covers N up to 256.
  function automatic logic [8:0] run_len(input logic [3:0] pass);
    return 9'd1 << pass;
  endfunction

  // The last pair of a pass starts at N - 2*run.
  function automatic logic last_pair(input logic [8:0] base,
                                     input logic [8:0] run,
                                     input logic [8:0] n);
    return base == (n - (run << 1));
  endfunction

endpackage

// File: rtl/merge_watchdog.sv
// Optional WAIT-state watchdog, present only when MERGE_TIMEOUT_EN is defined.
// Ports: clk/rst (sync, active-high); i_in_wait: sequencer is in WAIT; i_run_len: current run length;
//        o_timeout: this is the last allowed WAIT cycle (4*run_len+16 cycles) and no merge_done came.
`ifdef MERGE_TIMEOUT_EN
module merge_watchdog
  import merge_seq_pkg::*;
#(
  parameter int LOG2_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_in_wait,
  input  logic [LOG2_N-1:0] i_run_len,
  output logic              o_timeout
);

  logic [WD_CNT_W-1:0] r_cnt;
  logic [WD_CNT_W-1:0] w_limit;

  assign w_limit = (WD_CNT_W'(i_run_len) << 2) + WD_CNT_W'(16);

  // WAIT is never re-entered back to back, so clearing whenever we are
  // outside WAIT is the same as clearing on entry.
  always_ff @(posedge clk) begin
    if (rst || !i_in_wait) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + WD_CNT_W'(1);
    end
  end

  // r_cnt counts WAIT cycles already elapsed, so the cycle where it equals
  // limit-1 is the limit-th WAIT cycle; the sequencer leaves on the next edge.
  assign o_timeout = i_in_wait && (r_cnt == w_limit - WD_CNT_W'(1));

endmodule
`endif

// File: rtl/merge_pass_sequencer.sv
// Sequences a two-FIFO merge unit through a bottom-up merge sort of N = 2**LOG2_N bytes.
// Ports: clk/rst (sync, active-high); i_sort_req, i_abort, i_merge_done in; o_merge_start pulse,
//        o_merge_run_len/o_merge_src_l_addr/o_merge_src_r_addr/o_merge_dst_addr, o_src_bank,
//        o_pass_idx, o_sort_busy, o_sort_done pulse, o_sort_err. All outputs registered.
// Build option: define MERGE_TIMEOUT_EN to add the WAIT watchdog and drive o_sort_err.
module merge_pass_sequencer
  import merge_seq_pkg::*;
#(
  parameter int LOG2_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sort_req,
  input  logic              i_abort,
  input  logic              i_merge_done,
  output logic              o_merge_start,
  output logic [LOG2_N-1:0] o_merge_run_len,
  output logic [LOG2_N-1:0] o_merge_src_l_addr,
  output logic [LOG2_N-1:0] o_merge_src_r_addr,
  output logic [LOG2_N-1:0] o_merge_dst_addr,
  output logic              o_src_bank,
  output logic [3:0]        o_pass_idx,
  output logic              o_sort_busy,
  output logic              o_sort_done,
  output logic              o_sort_err
);

  localparam logic [8:0] N         = 9'd1 << LOG2_N;
  localparam logic [3:0] LAST_PASS = 4'(LOG2_N - 1);

  seq_state_t        r_state, w_state_nxt;
  logic [3:0]        r_pass_idx, w_pass_nxt;
  logic [LOG2_N-1:0] r_pair_base, w_base_nxt;
  logic [LOG2_N-1:0] r_run_len, w_run_nxt;
  logic [LOG2_N-1:0] r_r_addr, w_r_addr_nxt;
  logic              r_src_bank, w_bank_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_start, r_done;
  logic              w_last_pair;

  assign w_last_pair = last_pair(9'(r_pair_base), 9'(r_run_len), N);

`ifdef MERGE_TIMEOUT_EN
  logic r_err, w_err_nxt;
  logic w_timeout;

  merge_watchdog #(.LOG2_N(LOG2_N)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_in_wait (r_state == ST_WAIT),
    .i_run_len (r_run_len),
    .o_timeout (w_timeout)
  );
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pass_nxt  = r_pass_idx;
    w_base_nxt  = r_pair_base;
    w_run_nxt   = r_run_len;
    w_bank_nxt  = r_src_bank;
    w_busy_nxt  = r_busy;
`ifdef MERGE_TIMEOUT_EN
    w_err_nxt   = r_err;
`endif
    if (i_abort) begin
      // Abort wins over everything; address registers keep their values.
      w_state_nxt = ST_IDLE;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_sort_req) begin
            w_state_nxt = ST_LAUNCH;
            w_pass_nxt  = 4'd0;
            w_base_nxt  = '0;
            w_run_nxt   = LOG2_N'(run_len(4'd0));
            w_bank_nxt  = 1'b0;
            w_busy_nxt  = 1'b1;
`ifdef MERGE_TIMEOUT_EN
            w_err_nxt   = 1'b0;
`endif
          end
        end
        ST_LAUNCH: w_state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (i_merge_done) begin
            if (w_last_pair && (r_pass_idx == LAST_PASS)) begin
              w_state_nxt = ST_DONE;
              w_busy_nxt  = 1'b0;   // busy falls in the same cycle sort_done rises
            end else if (w_last_pair) begin
              w_state_nxt = ST_NEXT_PASS;
            end else begin
              w_state_nxt = ST_NEXT_PAIR;
            end
          end
`ifdef MERGE_TIMEOUT_EN
          else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_err_nxt   = 1'b1;
          end
`endif
        end
        ST_NEXT_PAIR: begin
          // Cannot wrap: this is never the last pair of the pass.
          w_base_nxt  = r_pair_base + (r_run_len << 1);
          w_state_nxt = ST_LAUNCH;
        end
        ST_NEXT_PASS: begin
          w_pass_nxt  = r_pass_idx + 4'd1;
          w_base_nxt  = '0;
          w_run_nxt   = LOG2_N'(run_len(r_pass_idx + 4'd1));
          w_bank_nxt  = ~r_src_bank;
          w_state_nxt = ST_LAUNCH;
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    w_r_addr_nxt = w_base_nxt + w_run_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pass_idx  <= '0;
      r_pair_base <= '0;
      r_run_len   <= '0;
      r_r_addr    <= '0;
      r_src_bank  <= 1'b0;
      r_busy      <= 1'b0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
`ifdef MERGE_TIMEOUT_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_pass_idx  <= w_pass_nxt;
      r_pair_base <= w_base_nxt;
      r_run_len   <= w_run_nxt;
      r_r_addr    <= w_r_addr_nxt;
      r_src_bank  <= w_bank_nxt;
      r_busy      <= w_busy_nxt;
      // Pulses are registered so they coincide with the LAUNCH / DONE state.
      r_start     <= (w_state_nxt == ST_LAUNCH);
      r_done      <= (w_state_nxt == ST_DONE);
`ifdef MERGE_TIMEOUT_EN
      r_err       <= w_err_nxt;
`endif
    end
  end

  assign o_merge_start      = r_start;
  assign o_merge_run_len    = r_run_len;
  assign o_merge_src_l_addr = r_pair_base;
  assign o_merge_src_r_addr = r_r_addr;
  assign o_merge_dst_addr   = r_pair_base;
  assign o_src_bank         = r_src_bank;
  assign o_pass_idx         = r_pass_idx;
  assign o_sort_busy        = r_busy;
  assign o_sort_done        = r_done;
`ifdef MERGE_TIMEOUT_EN
  assign o_sort_err         = r_err;
`else
  assign o_sort_err         = 1'b0;
`endif

endmodule
